// File: rtl/image_load_glue.sv
// image_load_glue: collects NUM_WORDS bus writes into a staging image and
// commits the full image to the accelerator, then waits for i_acc_done.
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_wr_valid          word write strobe, one word per high cycle
//   i_wr_data           word written
//   i_clear             synchronous soft abort/clear
//   i_acc_done          accelerator finished the current image (pulse)
//   o_ready             high while a write can be accepted
//   o_image_data        last committed image, word 0 at the LSBs
//   o_image_valid_pulse one-cycle pulse after a full-image commit
//   o_word_count        words captured in the current image
//   o_err_overrun       sticky: write arrived while not ready
module image_load_glue #(
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_wr_valid,
    input  logic [WORD_WIDTH-1:0]             i_wr_data,
    input  logic                              i_clear,
    input  logic                              i_acc_done,
    output logic                              o_ready,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]   o_image_data,
    output logic                              o_image_valid_pulse,
    output logic [CNT_W-1:0]                  o_word_count,
    output logic                              o_err_overrun
);

    localparam int unsigned IMG_W = NUM_WORDS * WORD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IMG_W-1:0]   staging_q, staging_d;
    logic [IMG_W-1:0]   image_q, image_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pulse_q, pulse_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            staging_q <= '0;
            image_q   <= '0;
            count_q   <= '0;
            pulse_q   <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            image_q   <= image_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state, word capture, commit and error logic
    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        image_d   = image_q;
        count_d   = count_q;
        pulse_d   = 1'b0;
        err_d     = err_q;

        if (i_clear) begin
            // Clear wins over everything; a concurrent write is silently dropped
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, FILL: begin
                    if (i_wr_valid) begin
                        for (int w = 0; w < int'(NUM_WORDS); w++) begin
                            if (CNT_W'(w) == count_q) begin
                                staging_d[w*WORD_WIDTH +: WORD_WIDTH] = i_wr_data;
                            end
                        end
                        if (count_q == LAST_IDX) begin
                            // Commit includes the word written this cycle
                            image_d = staging_d;
                            pulse_d = 1'b1;
                            count_d = '0;
                            state_d = BUSY;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                            state_d = FILL;
                        end
                    end
                end
                BUSY: begin
                    if (i_wr_valid) begin
                        err_d = 1'b1;
                    end
                    if (i_acc_done) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ready_d = (state_d != BUSY);
    end

    assign o_ready             = ready_q;
    assign o_image_data        = image_q;
    assign o_image_valid_pulse = pulse_q;
    assign o_word_count        = count_q;
    assign o_err_overrun       = err_q;

endmodule
